// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between result producers, the arbiter
// and the register file write ports.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int NUM_REQ        = 6,
  parameter int NUM_WPORTS     = 4
);
  logic [NUM_REQ-1:0]                   req_valid;
  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]    req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]        req_data;
  logic [NUM_REQ-1:0]                   req_ready;
  logic [NUM_WPORTS-1:0]                write_enable;
  logic [NUM_WPORTS*REG_ADDR_WIDTH-1:0] write_addr;
  logic [NUM_WPORTS*DATA_WIDTH-1:0]     write_data;
  logic                                 starve;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, write_enable, write_addr,
    input  write_data, starve
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, write_enable, write_addr,
    output write_data, starve
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter: grants up to NUM_WPORTS
// producers per cycle, serializes same-register writes.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int NUM_REQ        = 6,
  parameter int NUM_WPORTS     = 4,
  parameter int WAIT_WIDTH     = 4,
  parameter int STARVE_LIMIT   = 8
) (
  input logic                 i_Clk,
  input logic                 i_Rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [REG_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0]     data_t;
  typedef logic [WAIT_WIDTH-1:0]     wait_t;

  localparam wait_t LIMIT = wait_t'(STARVE_LIMIT);

  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         rr_ptr_next;
  wait_t                 wait_cnt  [NUM_REQ];
  wait_t                 wait_next [NUM_REQ];
  logic [NUM_REQ-1:0]    ready;
  logic [NUM_WPORTS-1:0] port_used;
  addr_t                 port_addr [NUM_WPORTS];
  data_t                 port_data [NUM_WPORTS];
  logic                  starve_next;

  assign bus.req_ready = ready;

  // Scan from rr_ptr, assign ports in grant order, hold duplicates.
  always_comb begin : grant_scan
    int     idx;
    int     used;
    logic   v;
    logic   dup;
    addr_t  a;
    data_t  d;
    ready       = '0;
    port_used   = '0;
    rr_ptr_next = rr_ptr;
    used        = 0;
    idx         = 0;
    v           = 1'b0;
    dup         = 1'b0;
    a           = '0;
    d           = '0;
    for (int p = 0; p < NUM_WPORTS; p++) begin
      port_addr[p] = '0;
      port_data[p] = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      v = 1'b0;
      a = '0;
      d = '0;
      for (int n = 0; n < NUM_REQ; n++) begin
        if (n == idx) begin
          v = bus.req_valid[n];
          a = bus.req_addr[n*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
          d = bus.req_data[n*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      dup = 1'b0;
      for (int p = 0; p < NUM_WPORTS; p++) begin
        if (port_used[p] && port_addr[p] == a) dup = 1'b1;
      end
      if (!i_Rst && v) begin
        if (a == '0) begin
          for (int n = 0; n < NUM_REQ; n++)
            if (n == idx) ready[n] = 1'b1;
        end else if (!dup && used < NUM_WPORTS) begin
          for (int n = 0; n < NUM_REQ; n++)
            if (n == idx) ready[n] = 1'b1;
          for (int p = 0; p < NUM_WPORTS; p++) begin
            if (p == used) begin
              port_used[p] = 1'b1;
              port_addr[p] = a;
              port_data[p] = d;
            end
          end
          used = used + 1;
          rr_ptr_next = PW'((idx + 1) % NUM_REQ);
        end
      end
    end
  end

  // Per-requester wait counters and the starvation flag input.
  always_comb begin : wait_calc
    starve_next = 1'b0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (bus.req_valid[n] && !ready[n])
        wait_next[n] = (wait_cnt[n] == '1) ? wait_cnt[n]
                                           : wait_cnt[n] + 1'b1;
      else
        wait_next[n] = '0;
      if (wait_next[n] >= LIMIT) starve_next = 1'b1;
    end
  end

  // Register write ports, pointer, counters and starve flag.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rr_ptr           <= '0;
      bus.starve       <= 1'b0;
      bus.write_enable <= '0;
      bus.write_addr   <= '0;
      bus.write_data   <= '0;
      for (int n = 0; n < NUM_REQ; n++) wait_cnt[n] <= '0;
    end else begin
      rr_ptr           <= rr_ptr_next;
      bus.starve       <= starve_next;
      bus.write_enable <= port_used;
      for (int n = 0; n < NUM_REQ; n++) wait_cnt[n] <= wait_next[n];
      for (int p = 0; p < NUM_WPORTS; p++) begin
        if (port_used[p]) begin
          bus.write_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] <= port_addr[p];
          bus.write_data[p*DATA_WIDTH +: DATA_WIDTH]         <= port_data[p];
        end
      end
    end
  end
endmodule
